// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one iterative divider between two ALU lanes.
// Owns the divider handshake, the divide-by-zero shortcut and flush/withdraw aborts.
module div_share_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [1:0]             req_valid_i,
    input  logic [1:0][1:0]        req_op_i,
    input  logic [1:0][DATA_W-1:0] req_src1_i,
    input  logic [1:0][DATA_W-1:0] req_src2_i,
    output logic [1:0]             resp_done_o,
    output logic [DATA_W-1:0]      resp_data_o,
    output logic [1:0]             stall_o,
    output logic                   busy_o,
    output logic                   div_start_o,
    output logic                   div_signed_o,
    output logic [DATA_W-1:0]      div_dividend_o,
    output logic [DATA_W-1:0]      div_divisor_o,
    input  logic                   div_done_i,
    input  logic [DATA_W-1:0]      div_quotient_i,
    input  logic [DATA_W-1:0]      div_remainder_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t              state;
    logic                lane_q;
    logic                last_grant;
    logic [1:0]          op_q;
    logic                signed_q;
    logic [DATA_W-1:0]   src1_q;
    logic [DATA_W-1:0]   src2_q;
    logic [DATA_W-1:0]   result_q;

    logic                gnt_any;
    logic                gnt_lane;
    logic                abort;
    logic                resp_fire;

    // Tie goes to the lane that did not complete last; a lone requester always wins.
    assign gnt_any  = |req_valid_i;
    assign gnt_lane = (&req_valid_i) ? ~last_grant : req_valid_i[1];
    assign abort    = flush | ~req_valid_i[lane_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            lane_q     <= 1'b0;
            last_grant <= 1'b1;
            op_q       <= 2'b00;
            signed_q   <= 1'b0;
            src1_q     <= '0;
            src2_q     <= '0;
            result_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!flush && gnt_any) begin
                        lane_q   <= gnt_lane;
                        op_q     <= req_op_i[gnt_lane];
                        signed_q <= ~req_op_i[gnt_lane][0];
                        src1_q   <= req_src1_i[gnt_lane];
                        src2_q   <= req_src2_i[gnt_lane];
                        if (req_src2_i[gnt_lane] == '0) begin
                            // Divide-by-zero never touches the divider.
                            result_q <= req_op_i[gnt_lane][1] ? req_src1_i[gnt_lane] : '1;
                            state    <= S_RESP;
                        end else begin
                            state <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= abort ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    // A started divide cannot be cancelled, so an abort must drain it
                    // unless the done pulse arrives in the same cycle.
                    if (abort) begin
                        state <= div_done_i ? S_IDLE : S_DRAIN;
                    end else if (div_done_i) begin
                        result_q <= op_q[1] ? div_remainder_i : div_quotient_i;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    last_grant <= lane_q;
                    state      <= S_IDLE;
                end
                S_DRAIN: begin
                    if (div_done_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign resp_fire      = (state == S_RESP) && !flush;
    assign resp_done_o    = resp_fire ? (lane_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_data_o    = resp_fire ? result_q : '0;
    assign stall_o        = req_valid_i & ~resp_done_o;
    assign busy_o         = (state != S_IDLE);
    assign div_start_o    = (state == S_LAUNCH) && !abort;
    assign div_signed_o   = signed_q;
    assign div_dividend_o = src1_q;
    assign div_divisor_o  = src2_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter; the bench plays both ALU lanes and the divider.
module tb_div_share_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [1:0]        req_valid;
    logic [1:0][1:0]   req_op;
    logic [1:0][31:0]  req_src1;
    logic [1:0][31:0]  req_src2;
    logic [1:0]        resp_done;
    logic [31:0]       resp_data;
    logic [1:0]        stall;
    logic              busy;
    logic              div_start;
    logic              div_signed;
    logic [31:0]       div_dividend;
    logic [31:0]       div_divisor;
    logic              div_done;
    logic [31:0]       div_quot;
    logic [31:0]       div_rem;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_share_arbiter #(.DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .req_valid_i     (req_valid),
        .req_op_i        (req_op),
        .req_src1_i      (req_src1),
        .req_src2_i      (req_src2),
        .resp_done_o     (resp_done),
        .resp_data_o     (resp_data),
        .stall_o         (stall),
        .busy_o          (busy),
        .div_start_o     (div_start),
        .div_signed_o    (div_signed),
        .div_dividend_o  (div_dividend),
        .div_divisor_o   (div_divisor),
        .div_done_i      (div_done),
        .div_quotient_i  (div_quot),
        .div_remainder_i (div_rem)
    );

    typedef struct {
        logic        lane;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] oh;
        oh = v.lane ? 2'b10 : 2'b01;
        @(negedge clk);
        req_valid = oh;
        req_op[v.lane] = v.op;
        req_src1[v.lane] = v.a;
        req_src2[v.lane] = v.b;
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_stall", {30'd0, stall}, {30'd0, oh});
        @(negedge clk); #1;
        if (v.b == 32'd0) begin
            chk("dz_no_start", {31'd0, div_start}, 32'd0);
            chk("dz_resp_done", {30'd0, resp_done}, {30'd0, oh});
            chk("dz_resp_data", resp_data, v.exp);
            chk("dz_stall_clr", {30'd0, stall}, 32'd0);
        end else begin
            chk("launch_start", {31'd0, div_start}, 32'd1);
            chk("launch_signed", {31'd0, div_signed}, {31'd0, ~v.op[0]});
            chk("launch_dividend", div_dividend, v.a);
            chk("launch_divisor", div_divisor, v.b);
            @(negedge clk); #1;
            chk("wait_start_low", {31'd0, div_start}, 32'd0);
            chk("wait_stall", {30'd0, stall}, {30'd0, oh});
            @(negedge clk);
            div_done = 1'b1; div_quot = v.q; div_rem = v.r;
            #1;
            chk("done_no_resp", {30'd0, resp_done}, 32'd0);
            @(negedge clk);
            div_done = 1'b0;
            #1;
            chk("resp_done", {30'd0, resp_done}, {30'd0, oh});
            chk("resp_data", resp_data, v.exp);
            chk("resp_stall_clr", {30'd0, stall}, 32'd0);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("post_resp_done", {30'd0, resp_done}, 32'd0);
        chk("post_resp_data", resp_data, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // lane, op, dividend, divisor, quotient, remainder, expected result
        tbl[0] = '{1'b0, 2'b00, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[1] = '{1'b1, 2'b11, 32'd100,       32'd7,  32'd14,        32'd2,         32'd2};
        tbl[2] = '{1'b0, 2'b00, 32'd5,         32'd0,  32'd0,         32'd0,         32'hFFFF_FFFF};
        tbl[3] = '{1'b0, 2'b10, 32'd5,         32'd0,  32'd0,         32'd0,         32'd5};
        tbl[4] = '{1'b1, 2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15,        32'h0FFF_FFFF};
        tbl[5] = '{1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[6] = '{1'b0, 2'b01, 32'd0,         32'd0,  32'd0,         32'd0,         32'hFFFF_FFFF};
        tbl[7] = '{1'b1, 2'b11, 32'd9,         32'd0,  32'd0,         32'd0,         32'd9};

        rst = 1'b1; flush = 1'b0; req_valid = 2'b00; req_op = '0;
        req_src1 = '0; req_src2 = '0; div_done = 1'b0; div_quot = '0; div_rem = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_resp_done", {30'd0, resp_done}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, div_start}, 32'd0);
        chk("rst_signed", {31'd0, div_signed}, 32'd0);
        chk("rst_dividend", div_dividend, 32'd0);
        chk("rst_divisor", div_divisor, 32'd0);
        chk("rst_stall", {30'd0, stall}, 32'd0);

        // Both lanes request continuously: lane 0 first, then strict alternation.
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b11;
        req_op[0] = 2'b01; req_src1[0] = 32'd40; req_src2[0] = 32'd4;
        req_op[1] = 2'b01; req_src1[1] = 32'd55; req_src2[1] = 32'd5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("rr_start", {31'd0, div_start}, 32'd1);
            chk("rr_dividend", div_dividend, (k % 2 == 0) ? 32'd40 : 32'd55);
            @(negedge clk);
            div_done = 1'b1;
            div_quot = (k % 2 == 0) ? 32'd10 : 32'd11;
            div_rem  = 32'd0;
            #1;
            @(negedge clk);
            div_done = 1'b0;
            #1;
            chk("rr_resp_lane", {30'd0, resp_done}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_resp_data", resp_data, (k % 2 == 0) ? 32'd10 : 32'd11);
            @(negedge clk);
            if (k == 3) req_valid = 2'b00;
            #1;
            chk("rr_idle", {31'd0, busy}, 32'd0);
        end

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Flush during WAIT drains the divider silently, then lane 1 runs normally.
        @(negedge clk);
        req_valid = 2'b01; req_op[0] = 2'b01; req_src1[0] = 32'd20; req_src2[0] = 32'd3;
        @(negedge clk); #1;
        chk("fl_launch", {31'd0, div_start}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_wait_start", {31'd0, div_start}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 2'b10; req_op[1] = 2'b11; req_src1[1] = 32'd23; req_src2[1] = 32'd5;
        #1;
        chk("fl_drain_busy", {31'd0, busy}, 32'd1);
        chk("fl_drain_start", {31'd0, div_start}, 32'd0);
        @(negedge clk);
        div_done = 1'b1; div_quot = 32'd6; div_rem = 32'd2;
        #1;
        chk("fl_drain_no_resp", {30'd0, resp_done}, 32'd0);
        @(negedge clk);
        div_done = 1'b0;
        #1;
        chk("fl_idle", {31'd0, busy}, 32'd0);
        chk("fl_idle_resp", {30'd0, resp_done}, 32'd0);
        chk("fl_idle_stall", {30'd0, stall}, 32'd2);
        @(negedge clk); #1;
        chk("fl_l1_start", {31'd0, div_start}, 32'd1);
        chk("fl_l1_dividend", div_dividend, 32'd23);
        @(negedge clk);
        @(negedge clk);
        div_done = 1'b1; div_quot = 32'd4; div_rem = 32'd3;
        @(negedge clk);
        div_done = 1'b0;
        #1;
        chk("fl_l1_resp", {30'd0, resp_done}, 32'd2);
        chk("fl_l1_data", resp_data, 32'd3);
        @(negedge clk);
        req_valid = 2'b00;

        // Withdrawal in LAUNCH: no start, back to IDLE.
        @(negedge clk);
        req_valid = 2'b01; req_op[0] = 2'b00; req_src1[0] = 32'd8; req_src2[0] = 32'd2;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("wd_no_start", {31'd0, div_start}, 32'd0);
        @(negedge clk); #1;
        chk("wd_idle", {31'd0, busy}, 32'd0);

        // Abort and done together in WAIT: straight to IDLE, no response.
        @(negedge clk);
        req_valid = 2'b01; req_src1[0] = 32'd9; req_src2[0] = 32'd3;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; div_done = 1'b1; div_quot = 32'd3; div_rem = 32'd0;
        #1;
        chk("ad_no_resp", {30'd0, resp_done}, 32'd0);
        @(negedge clk);
        flush = 1'b0; div_done = 1'b0; req_valid = 2'b00;
        #1;
        chk("ad_idle", {31'd0, busy}, 32'd0);
        chk("ad_idle_resp", {30'd0, resp_done}, 32'd0);

        // Flush in RESP suppresses the divide-by-zero pulse.
        @(negedge clk);
        req_valid = 2'b10; req_op[1] = 2'b00; req_src1[1] = 32'd1; req_src2[1] = 32'd0;
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fr_no_resp", {30'd0, resp_done}, 32'd0);
        chk("fr_no_data", resp_data, 32'd0);
        @(negedge clk);
        flush = 1'b0; req_valid = 2'b00;
        #1;
        chk("fr_idle", {31'd0, busy}, 32'd0);

        // Reset mid-operation returns to IDLE.
        @(negedge clk);
        req_valid = 2'b01; req_op[0] = 2'b01; req_src1[0] = 32'd8; req_src2[0] = 32'd2;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00;
        #1;
        chk("mr_idle", {31'd0, busy}, 32'd0);
        chk("mr_dividend", div_dividend, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
